// File: rtl/dfs_path_unloader.sv
// rtl/dfs_path_unloader.sv - streams the best DFS path from path memory to the host
//
// Purpose: once the search controller raises done, emit a header beat carrying
// the minimum path weight followed by one beat per path node (address order),
// then pulse stop so the controller can return to its START state.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   done                 search result valid (level)
//   path_len, min_wt     result length and weight, sampled with done in IDLE
//   pm_rd_en/addr/data   path memory read port, data valid one cycle after en
//   out_valid/ready      host handshake
//   out_data             header = weight, node beats = zero-extended node id
//   out_first, out_last  header / final beat markers
//   stop                 one-cycle release pulse to the search controller
//   busy                 high whenever not IDLE
module dfs_path_unloader #(
  parameter int DW = 8,
  parameter int AW = 4,
  parameter int WW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          done,
  input  logic [AW:0]   path_len,
  input  logic [WW-1:0] min_wt,
  output logic          pm_rd_en,
  output logic [AW-1:0] pm_rd_addr,
  input  logic [DW-1:0] pm_rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WW-1:0] out_data,
  output logic          out_first,
  output logic          out_last,
  output logic          stop,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_FETCH, S_WAIT, S_SEND, S_ACK, S_DRAIN
  } state_t;

  localparam logic [AW:0] MAX_LEN = (AW+1)'(1) << AW;

  state_t        state, state_nxt;
  logic [AW:0]   len;
  logic [WW-1:0] wt;
  logic [AW-1:0] idx;
  logic [WW-1:0] node_q;
  logic          node_last;

  // idx is widened before the compare so len = 2^AW does not wrap.
  assign node_last = ({1'b0, idx} == (len - (AW+1)'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      len    <= '0;
      wt     <= '0;
      idx    <= '0;
      node_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (done) begin
          len <= (path_len > MAX_LEN) ? MAX_LEN : path_len;
          wt  <= min_wt;
          idx <= '0;
        end
        S_WAIT: node_q <= WW'(pm_rd_data);
        S_SEND: if (out_ready && !node_last) idx <= idx + AW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    pm_rd_en   = 1'b0;
    pm_rd_addr = '0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_first  = 1'b0;
    out_last   = 1'b0;
    stop       = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: if (done) state_nxt = S_HDR;
      S_HDR: begin
        out_valid = 1'b1;
        out_data  = wt;
        out_first = 1'b1;
        out_last  = (len == '0);
        if (out_ready) state_nxt = (len == '0) ? S_ACK : S_FETCH;
      end
      S_FETCH: begin
        pm_rd_en   = 1'b1;
        pm_rd_addr = idx;
        state_nxt  = S_WAIT;
      end
      S_WAIT: state_nxt = S_SEND;
      S_SEND: begin
        out_valid = 1'b1;
        out_data  = node_q;
        out_last  = node_last;
        if (out_ready) state_nxt = node_last ? S_ACK : S_FETCH;
      end
      S_ACK: begin
        stop      = 1'b1;
        state_nxt = S_DRAIN;
      end
      // Hold here until done drops so the same result is not unloaded twice.
      S_DRAIN: if (!done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dfs_path_unloader.sv
// tb/tb_dfs_path_unloader.sv - scoreboard bench for dfs_path_unloader
module tb_dfs_path_unloader;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        done = 0;
  logic [4:0]  path_len = '0;
  logic [15:0] min_wt = '0;
  logic        pm_rd_en;
  logic [3:0]  pm_rd_addr;
  logic [7:0]  pm_rd_data = '0;
  logic        out_valid;
  logic        out_ready = 1;
  logic [15:0] out_data;
  logic        out_first, out_last, stop, busy;

  dfs_path_unloader #(.DW(8), .AW(4), .WW(16)) dut (
    .clk(clk), .rst_n(rst_n), .done(done), .path_len(path_len), .min_wt(min_wt),
    .pm_rd_en(pm_rd_en), .pm_rd_addr(pm_rd_addr), .pm_rd_data(pm_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_first(out_first), .out_last(out_last), .stop(stop), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic        f;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  logic [7:0] mem [16];
  int checks = 0;
  int errors = 0;
  int stop_cnt = 0;
  int rd_cnt = 0;
  int cyc = 0;
  int last_hs = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: never
  logic prev_stall = 0;
  beat_t prev_beat;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pm_rd_en) pm_rd_data <= mem[pm_rd_addr];
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (stop) stop_cnt++;
      if (pm_rd_en) rd_cnt++;
      if (prev_stall) begin
        checks++;
        if (!out_valid || out_data != prev_beat.d || out_first != prev_beat.f || out_last != prev_beat.l) begin
          errors++;
          $display("FAIL stall_stable: got v=%0b d=%h f=%0b l=%0b want d=%h f=%0b l=%0b",
                   out_valid, out_data, out_first, out_last, prev_beat.d, prev_beat.f, prev_beat.l);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got d=%h f=%0b l=%0b want no beat", out_data, out_first, out_last);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (out_data != e.d || out_first != e.f || out_last != e.l) begin
            errors++;
            $display("FAIL beat: got d=%h f=%0b l=%0b want d=%h f=%0b l=%0b",
                     out_data, out_first, out_last, e.d, e.f, e.l);
          end
        end
        if (ready_mode == 0 && !out_first) begin
          checks++;
          if (cyc - last_hs != 3) begin
            errors++;
            $display("FAIL beat_spacing: got %0d cycles want 3", cyc - last_hs);
          end
        end
        last_hs = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = '{d: out_data, f: out_first, l: out_last};
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, {pm_rd_en, pm_rd_addr, out_valid, out_data, out_first, out_last, stop, busy}, 0);
  endtask

  task automatic push_expected(input int n, input logic [15:0] w);
    int ns;
    ns = (n > 16) ? 16 : n;
    exp_q.push_back('{d: w, f: 1'b1, l: (ns == 0)});
    for (int i = 0; i < ns; i++)
      exp_q.push_back('{d: {8'h00, mem[i]}, f: 1'b0, l: (i == ns - 1)});
  endtask

  // One full unload: wait for stop, optionally keep done high for hold cycles.
  task automatic run_seq(input int n, input logic [15:0] w, input int mode, input int hold);
    int s0, r0, t, ns;
    ns = (n > 16) ? 16 : n;
    push_expected(n, w);
    s0 = stop_cnt;
    r0 = rd_cnt;
    ready_mode = mode;
    @(posedge clk);
    #2;
    path_len = 5'(n);
    min_wt   = w;
    done     = 1;
    t = 0;
    while (stop_cnt == s0 && t < 500) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("stop_timeout", (t < 500) ? 1 : 0, 1);
    path_len = 5'd2;   // changes after capture must be ignored
    repeat (hold + 2) @(posedge clk);
    #2;
    check("stop_pulses", stop_cnt - s0, 1);
    check("reads", rd_cnt - r0, ns);
    check("queue_empty", exp_q.size(), 0);
    if (hold > 0) check("busy_in_drain", busy, 1);
    done = 0;
    repeat (2) @(posedge clk);
    #2;
    check("busy_after_drain", busy, 0);
    ready_mode = 0;
  endtask

  initial begin
    int s0;
    int t;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    repeat (3) @(posedge clk);
    #2;
    check_idle_outputs("reset_outputs");
    rst_n = 1;
    repeat (3) @(posedge clk);
    #2;
    check_idle_outputs("idle_no_done");

    // three nodes, full throughput
    mem[0] = 8'd5; mem[1] = 8'd9; mem[2] = 8'd2;
    run_seq(3, 16'h0123, 0, 0);

    // empty path: header only
    run_seq(0, 16'h00FF, 0, 0);

    // three nodes under random backpressure
    run_seq(3, 16'h0123, 1, 0);

    // done held high after stop: must not replay, then a fresh sequence
    run_seq(3, 16'h0042, 0, 50);
    run_seq(3, 16'h0043, 0, 0);

    // full-length path and over-length saturation
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    run_seq(16, 16'hBEEF, 0, 0);
    run_seq(31, 16'h7777, 0, 0);

    // reset during the SEND of node 1
    mem[0] = 8'd5; mem[1] = 8'd9; mem[2] = 8'd2;
    push_expected(3, 16'h0123);
    s0 = stop_cnt;
    path_len = 5'd3;
    min_wt   = 16'h0123;
    done     = 1;
    t = 0;
    do begin
      @(posedge clk);
      #2;
      t++;
    end while (!(out_valid && !out_first && out_data == 16'h0009) && t < 50);
    check("reach_node1", (t < 50) ? 1 : 0, 1);
    ready_mode = 2;
    out_ready  = 0;
    rst_n      = 0;
    @(posedge clk);
    #2;
    check_idle_outputs("mid_reset_outputs");
    check("abandoned_beats", exp_q.size(), 2);
    exp_q.delete();
    rst_n = 1;
    done  = 0;
    ready_mode = 0;
    repeat (4) @(posedge clk);
    #2;
    check("no_stop_on_reset", stop_cnt - s0, 0);
    check_idle_outputs("idle_after_reset");
    run_seq(3, 16'h0123, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
